// File: rtl/frame_stream_tx_if.sv
// Frame-buffer read port plus pixel stream output of frame_stream_tx.
// master = the transmitter, slave = the frame-buffer / sink side.
interface frame_stream_tx_if;
    logic        start_in;
    logic [16:0] addr_out;
    logic [15:0] rd_data_in;
    logic [15:0] pixel_out;
    logic        valid_pixel_out;
    logic        frame_done_out;
    logic        busy_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;

    modport master (
        input  start_in, rd_data_in,
        output addr_out, pixel_out, valid_pixel_out, frame_done_out,
        busy_out, hcount_out, vcount_out
    );
    modport slave (
        output start_in, rd_data_in,
        input  addr_out, pixel_out, valid_pixel_out, frame_done_out,
        busy_out, hcount_out, vcount_out
    );
endinterface

// File: rtl/frame_stream_tx.sv
// Streams one frame from a frame buffer, one pixel every BRAM_LATENCY+1+GAP_CYCLES
// cycles, with row-major addressing and strobed pixel output.
module frame_stream_tx #(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 240,
    parameter int BRAM_LATENCY = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic              system_clk_in,
    input  logic              rst_in,
    frame_stream_tx_if.master fs
);
    typedef enum logic [2:0] {IDLE, FETCH, SEND, GAP, DONE} state_t;

    localparam logic [3:0]  FETCH_LAST = 4'(BRAM_LATENCY - 1);
    localparam logic [3:0]  GAP_LAST   = 4'(GAP_CYCLES - 1);
    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [10:0] h_q;
    logic [9:0]  v_q;
    logic [16:0] addr_q;
    logic [15:0] pix_q;
    logic [10:0] hout_q;
    logic [9:0]  vout_q;
    logic        vld_q, done_q, busy_q;

    logic eol, last_px;
    assign eol     = (h_q == H_LAST);
    assign last_px = eol && (v_q == V_LAST);

    always_ff @(posedge system_clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            pix_q   <= '0;
            hout_q  <= '0;
            vout_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fs.start_in) begin
                        state_q <= FETCH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    // Address has been stable for BRAM_LATENCY cycles at this edge.
                    if (cnt_q == FETCH_LAST) begin
                        state_q <= SEND;
                        pix_q   <= fs.rd_data_in;
                        hout_q  <= h_q;
                        vout_q  <= v_q;
                        vld_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                SEND: begin
                    state_q <= GAP;
                    cnt_q   <= '0;
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (last_px) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            h_q     <= '0;
                            v_q     <= '0;
                            addr_q  <= '0;
                        end else begin
                            state_q <= FETCH;
                            addr_q  <= addr_q + 17'd1;
                            h_q     <= eol ? 11'd0 : h_q + 11'd1;
                            v_q     <= eol ? v_q + 10'd1 : v_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fs.addr_out        = addr_q;
    assign fs.pixel_out       = pix_q;
    assign fs.hcount_out      = hout_q;
    assign fs.vcount_out      = vout_q;
    assign fs.valid_pixel_out = vld_q;
    assign fs.frame_done_out  = done_q;
    assign fs.busy_out        = busy_q;
endmodule

// File: tb/tb_frame_stream_tx.sv
// Two transmitters: A (320x3, latency 2, gap 1) and B (4x2, latency 1, gap 3),
// checked every cycle against a timing model derived from the pixel period.
module tb_frame_stream_tx;
    localparam int HA = 320, VA = 3, BLA = 2, GA = 1;
    localparam int PA = BLA + 1 + GA, NA = HA * VA;
    localparam int HB = 4, VB = 2, BLB = 1, GB = 3;
    localparam int PB = BLB + 1 + GB, NB = HB * VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA, rstB;
    frame_stream_tx_if ifa();
    frame_stream_tx_if ifb();

    frame_stream_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .BRAM_LATENCY(BLA), .GAP_CYCLES(GA))
        dut_a (.system_clk_in(clk), .rst_in(rstA), .fs(ifa));
    frame_stream_tx #(.H_ACTIVE(HB), .V_ACTIVE(VB), .BRAM_LATENCY(BLB), .GAP_CYCLES(GB))
        dut_b (.system_clk_in(clk), .rst_in(rstB), .fs(ifb));

    function automatic logic [15:0] fA(input logic [16:0] n);
        return n[15:0];
    endfunction
    function automatic logic [15:0] fB(input logic [16:0] n);
        logic [15:0] t;
        t = n[15:0];
        return t * 16'd257 + 16'h00A5;
    endfunction

    // frame buffers: A has one register stage, B is combinational
    logic [16:0] ahA;
    always @(posedge clk) ahA <= ifa.addr_out;
    assign ifa.rd_data_in = fA(ahA);
    assign ifb.rd_data_in = fB(ifb.addr_out);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [1:0] smpA, smpB;
    always @(posedge clk) begin
        smpA <= {rstA, ifa.start_in};
        smpB <= {rstB, ifb.start_in};
    end

    int nvec = 0, nfail = 0;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // d = edges since the edge that sampled start; frame spans d = 0 .. P*N
    task automatic model_step(input bit r, input bit st, input int P, input int N,
                              inout bit act, inout int d);
        if (r) begin act = 0; d = 0; end
        else if (act) begin d++; if (d > P * N) act = 0; end
        else if (st) begin act = 1; d = 0; end
    endtask
    task automatic model_out(input bit act, input int d, input int BL, input int P, input int N,
                             output logic [2:0] ctl, output int addr, output int k);
        bit v;
        v    = act && d >= BL && d < P * N && ((d - BL) % P) == 0;
        k    = v ? (d - BL) / P : 0;
        ctl  = {v, act && d == P * N, act};
        addr = (act && d < P * N) ? d / P : 0;
    endtask

    bit actA = 0, actB = 0, prvA = 0, prvB = 0;
    int dA = 0, dB = 0;
    logic [15:0] lpA = 0, lpB = 0;
    int lhA = 0, lvA = 0, lhB = 0, lvB = 0;
    int sA_cyc[$], sB_cyc[$], dnA[$], dnB[$];
    logic [36:0] sA_val[$], sB_val[$];

    initial begin
        logic [2:0] ctl;
        int ea, k;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                model_step(smpA[1], smpA[0], PA, NA, actA, dA);
                model_out(actA, dA, BLA, PA, NA, ctl, ea, k);
                if (smpA[1]) begin lpA = 0; lhA = 0; lvA = 0; end
                else if (ctl[2]) begin lpA = fA(17'(k)); lhA = k % HA; lvA = k / HA; end
                chk("A_outputs", {ifa.valid_pixel_out, ifa.frame_done_out, ifa.busy_out,
                    ifa.addr_out, ifa.pixel_out, ifa.hcount_out, ifa.vcount_out},
                    {ctl, 17'(ea), lpA, 11'(lhA), 10'(lvA)});
                chk("A_no_double_strobe", 64'(prvA & ifa.valid_pixel_out), 0);
                prvA = ifa.valid_pixel_out;
                if (ifa.valid_pixel_out === 1'b1) begin
                    sA_cyc.push_back(cyc);
                    sA_val.push_back({ifa.hcount_out, ifa.vcount_out, ifa.pixel_out});
                end
                if (ifa.frame_done_out === 1'b1) dnA.push_back(cyc);

                model_step(smpB[1], smpB[0], PB, NB, actB, dB);
                model_out(actB, dB, BLB, PB, NB, ctl, ea, k);
                if (smpB[1]) begin lpB = 0; lhB = 0; lvB = 0; end
                else if (ctl[2]) begin lpB = fB(17'(k)); lhB = k % HB; lvB = k / HB; end
                chk("B_outputs", {ifb.valid_pixel_out, ifb.frame_done_out, ifb.busy_out,
                    ifb.addr_out, ifb.pixel_out, ifb.hcount_out, ifb.vcount_out},
                    {ctl, 17'(ea), lpB, 11'(lhB), 10'(lvB)});
                chk("B_no_double_strobe", 64'(prvB & ifb.valid_pixel_out), 0);
                prvB = ifb.valid_pixel_out;
                if (ifb.valid_pixel_out === 1'b1) begin
                    sB_cyc.push_back(cyc);
                    sB_val.push_back({ifb.hcount_out, ifb.vcount_out, ifb.pixel_out});
                end
                if (ifb.frame_done_out === 1'b1) dnB.push_back(cyc);
            end
        end
    end

    task automatic run_a();
        int e0, n, bad;
        ifa.start_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstA = 1'b0;
        chk("A_reset_state", {ifa.busy_out, ifa.addr_out, ifa.valid_pixel_out}, 0);
        // frame 1, with a start pulse injected mid-frame
        sA_cyc.delete(); sA_val.delete(); dnA.delete();
        ifa.start_in = 1'b1;
        @(posedge clk); #1 ifa.start_in = 1'b0;
        e0 = cyc;
        n = 0;
        while (sA_cyc.size() < 100 && n < 2000) begin @(posedge clk); #1 n++; end
        chk("A_wait_px100", 64'(sA_cyc.size() >= 100), 1);
        ifa.start_in = 1'b1;
        @(posedge clk); #1 ifa.start_in = 1'b0;
        n = 0;
        while (dnA.size() == 0 && n < 6000) begin @(posedge clk); #1 n++; end
        chk("A_wait_done", 64'(dnA.size()), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("A_strobe_count", 64'(sA_cyc.size()), NA);
        chk("A_first_strobe_edge", 64'(sA_cyc[0]), 64'(e0 + 2));
        chk("A_first_pixel", sA_val[0], 0);
        bad = 0;
        for (int i = 1; i < sA_cyc.size(); i++) if (sA_cyc[i] - sA_cyc[i-1] != 4) bad++;
        chk("A_strobe_spacing", 64'(bad), 0);
        chk("A_strobe_319", sA_val[319], {11'd319, 10'd0, 16'h013F});
        chk("A_strobe_320", sA_val[320], {11'd0, 10'd1, 16'h0140});
        chk("A_strobe_last", sA_val[NA-1], {11'd319, 10'd2, 16'h03BF});
        chk("A_done_edge", 64'(dnA[0]), 64'(e0 + 4 * NA));
        chk("A_done_count", 64'(dnA.size()), 1);
        chk("A_idle_after", {ifa.busy_out, ifa.addr_out}, 0);
        // frame 2 aborted by reset
        sA_cyc.delete(); sA_val.delete(); dnA.delete();
        ifa.start_in = 1'b1;
        @(posedge clk); #1 ifa.start_in = 1'b0;
        n = 0;
        while (sA_cyc.size() < 500 && n < 3000) begin @(posedge clk); #1 n++; end
        chk("A_wait_px500", 64'(sA_cyc.size() >= 500), 1);
        rstA = 1'b1;
        @(posedge clk); #1 rstA = 1'b0;
        chk("A_abort_outputs", {ifa.valid_pixel_out, ifa.frame_done_out, ifa.busy_out,
            ifa.addr_out, ifa.pixel_out, ifa.hcount_out, ifa.vcount_out}, 0);
        repeat (50) @(posedge clk);
        #1 chk("A_abort_no_done", 64'(dnA.size()), 0);
        // restart begins at (0,0)
        sA_cyc.delete(); sA_val.delete();
        ifa.start_in = 1'b1;
        @(posedge clk); #1 ifa.start_in = 1'b0;
        e0 = cyc;
        n = 0;
        while (sA_cyc.size() < 2 && n < 50) begin @(posedge clk); #1 n++; end
        chk("A_wait_restart", 64'(sA_cyc.size() >= 2), 1);
        chk("A_restart_edge", 64'(sA_cyc[0]), 64'(e0 + 2));
        chk("A_restart_px0", sA_val[0], 0);
        chk("A_restart_px1", sA_val[1], {11'd1, 10'd0, 16'h0001});
    endtask

    task automatic run_b();
        int e0, n, bad;
        ifb.start_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstB = 1'b0;
        chk("B_reset_state", {ifb.busy_out, ifb.addr_out, ifb.frame_done_out}, 0);
        sB_cyc.delete(); sB_val.delete(); dnB.delete();
        ifb.start_in = 1'b1;
        @(posedge clk); #1 e0 = cyc;
        n = 0;
        while (dnB.size() < 2 && n < 300) begin @(posedge clk); #1 n++; end
        ifb.start_in = 1'b0;
        chk("B_wait_two_frames", 64'(dnB.size()), 2);
        repeat (10) @(posedge clk);
        #1;
        chk("B_strobe_count", 64'(sB_cyc.size()), 2 * NB);
        chk("B_first_strobe_edge", 64'(sB_cyc[0]), 64'(e0 + 1));
        bad = 0;
        for (int i = 1; i < NB; i++) if (sB_cyc[i] - sB_cyc[i-1] != 5) bad++;
        chk("B_strobe_spacing", 64'(bad), 0);
        chk("B_done_edge", 64'(dnB[0]), 64'(e0 + 40));
        chk("B_second_frame_start", 64'(sB_cyc[NB]), 64'(dnB[0] + 3));
        chk("B_second_done", 64'(dnB[1]), 64'(dnB[0] + 42));
        chk("B_px5", sB_val[5], {11'd1, 10'd1, 16'h05AA});
        chk("B_px7_hold", {ifb.pixel_out, ifb.hcount_out, ifb.vcount_out},
            {16'h07AC, 11'd3, 10'd1});
    endtask

    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        ifa.start_in = 1'b0;
        ifb.start_in = 1'b0;
        fork
            run_a();
            run_b();
        join
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
